multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 3, width of ALU_op_o (legal >= 3; encodings zero-extended).
REQ-002 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-004 clk_i  in  1  rising-edge clock.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 instr_op_i  in  6  opcode field from the external instruction register.
REQ-007 mem_ready_i  in  1  memory access completes in a cycle where this is high and a Mem* strobe is high.
REQ-008 PCWrite_o, IRWrite_o  out  1 each  PC update / IR load strobes.
REQ-009 RegWrite_o, ALUSrc_o, RegDst_o, Branch_o, MemWrite_o, MemRead_o, MemtoReg_o  out  1 each  datapath controls.
REQ-010 ALU_op_o  out  ALU_OP_W  ALU operation class.
REQ-011 state_o  out  3  current state code; illegal_o  out  1  one-cycle pulse on unknown opcode.
REQ-012 instr_cnt_o  out  CNT_W  retired-instruction count.

Function
REQ-013 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, JUMP=6; codes 7 unused -> IDLE.
REQ-014 All outputs SHALL be Moore: decoded only from the state register and a 6-bit opcode register op_q.
REQ-015 IDLE: all controls 0; unconditionally -> FETCH next cycle.
REQ-016 FETCH: MemRead_o=1; stay while mem_ready_i=0; on mem_ready_i=1 assert IRWrite_o=1 and PCWrite_o=1 that same cycle, -> DECODE.
REQ-017 DECODE: op_q <= instr_op_i; one cycle; unknown opcode -> illegal_o=1 for that cycle, -> FETCH, not counted as retired.
REQ-018 Opcodes: R=000000, addi=001000, slti=001010, lw=100011, sw=101011, beq=000100, bne=000101, j=000010 (see REQ-029).
REQ-019 EXEC ALU_op_o: R=010, lw/sw/addi=000, beq/bne=001, slti=011; ALUSrc_o=1 for addi/slti/lw/sw; Branch_o=1 for beq/bne.
REQ-020 EXEC transitions: R/addi/slti -> WB; lw/sw -> MEM; beq/bne -> FETCH (branch retires here).
REQ-021 MEM: lw MemRead_o=1, sw MemWrite_o=1; hold until mem_ready_i=1; then lw -> WB, sw -> FETCH (sw retires).
REQ-022 WB: RegWrite_o=1 one cycle; RegDst_o=1 for R only; MemtoReg_o=1 for lw only; -> FETCH (retires).
REQ-023 Controls not listed for a state SHALL be 0; ALU_op_o=0 outside EXEC.
REQ-024 instr_cnt_o SHALL increment by 1 on each retiring cycle, wrap from 2^CNT_W-1 to 0 silently.
REQ-025 Latency: R/addi/slti = 4 cycles, lw = 5, sw = 4, beq/bne = 3 (zero-wait memory).

Reset
REQ-026 rst_i=1 at any edge SHALL force state IDLE, op_q=0, instr_cnt_o=0; all outputs 0 in following cycle.
REQ-027 Reset mid-MEM/WB SHALL abort the access; no strobe asserted after the reset edge; no retirement counted.
REQ-028 Reset has priority over mem_ready_i and every transition.

Configuration
REQ-029 Macro MCC_JUMP_EN: defined -> opcode 000010 goes DECODE -> JUMP (PCWrite_o=1, one cycle) -> FETCH, retires; undefined -> 000010 is illegal per REQ-017 and state JUMP is unreachable.

Verification
REQ-030 Reset 2 cycles, then mem_ready_i=1 always -> state_o 0,1,2 ...; all controls 0 during reset and in IDLE.
REQ-031 R-type, zero-wait -> FETCH,DECODE,EXEC(ALU_op=010),WB(RegWrite=1,RegDst=1); instr_cnt_o 0->1.
REQ-032 lw with mem_ready_i low 3 cycles in MEM -> MemRead_o held 4 cycles, then WB MemtoReg_o=1; total 8 cycles.
REQ-033 Opcode 111111 -> illegal_o pulses once in DECODE, back to FETCH, instr_cnt_o unchanged; repeat with 000010 with/without MCC_JUMP_EN.
REQ-034 sw in MEM with MemWrite_o=1, rst_i=1 one cycle -> MemWrite_o=0 next cycle, state_o=0, instr_cnt_o=0.
REQ-035 CNT_W=4, 17 beq instructions -> instr_cnt_o wraps 15->0, ends at 1.

Source files
------------

// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
//   Control FSM for a multi-cycle MIPS-style datapath. It walks each
//   instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB (and JUMP when enabled).
//   It drives the datapath strobes and counts retired instructions.
//
// Build option:
//   MCC_JUMP_EN  when defined, opcode 000010 (j) goes DECODE -> JUMP -> FETCH
//                and retires. When undefined, 000010 is an illegal opcode and
//                JUMP is never entered.
//
// Parameters:
//   ALU_OP_W  width of ALU_op_o (>= 3, class codes zero-extended)
//   CNT_W     width of the retired-instruction counter
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   instr_op_i   opcode field of the external instruction register
//   mem_ready_i  memory handshake; an access completes when high with a
//                Mem* strobe high
//   PCWrite_o, IRWrite_o             PC update / IR load strobes
//   RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
//   MemWrite_o, MemRead_o, MemtoReg_o datapath controls
//   ALU_op_o     ALU operation class
//   state_o      current state code
//   illegal_o    one-cycle pulse in DECODE for an unknown opcode
//   instr_cnt_o  retired-instruction count (wraps silently)
// -----------------------------------------------------------------------------
module multi_cycle_control #(
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          instr_op_i,
  input  logic                mem_ready_i,
  output logic                PCWrite_o,
  output logic                IRWrite_o,
  output logic                RegWrite_o,
  output logic                ALUSrc_o,
  output logic                RegDst_o,
  output logic                Branch_o,
  output logic                MemWrite_o,
  output logic                MemRead_o,
  output logic                MemtoReg_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic [2:0]          state_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    instr_cnt_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    JUMP   = 3'd6
  } stateT;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
`ifdef MCC_JUMP_EN
  localparam logic [5:0] OpJ    = 6'b000010;
`endif

  // Registered control bundle; PCWrite here only covers the JUMP state.
  typedef struct packed {
    logic       pcWrite;
    logic       regWrite;
    logic       aluSrc;
    logic       regDst;
    logic       branch;
    logic       memWrite;
    logic       memRead;
    logic       memtoReg;
    logic [2:0] aluOp;
  } ctrlT;

  stateT            stateQ, stateNext;
  logic [5:0]       opQ, opNext;
  logic [CNT_W-1:0] cntQ;
  ctrlT             ctrlQ;
  logic             retire;
  logic             fetchDone;

  function automatic logic isKnownOp(input logic [5:0] op);
    logic known;
    case (op)
      OpR, OpAddi, OpSlti, OpLw, OpSw, OpBeq, OpBne: known = 1'b1;
`ifdef MCC_JUMP_EN
      OpJ:                                          known = 1'b1;
`endif
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

  // Control levels that belong to a given (state, opcode) pair.
  function automatic ctrlT decodeCtrl(input stateT s, input logic [5:0] op);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: c.memRead = 1'b1;
      EXEC: begin
        case (op)
          OpR:          c.aluOp = 3'b010;
          OpAddi:       c.aluSrc = 1'b1;
          OpLw, OpSw:   c.aluSrc = 1'b1;
          OpSlti: begin
            c.aluOp  = 3'b011;
            c.aluSrc = 1'b1;
          end
          OpBeq, OpBne: begin
            c.aluOp  = 3'b001;
            c.branch = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        c.memRead  = (op == OpLw);
        c.memWrite = (op == OpSw);
      end
      WB: begin
        c.regWrite = 1'b1;
        c.regDst   = (op == OpR);
        c.memtoReg = (op == OpLw);
      end
      JUMP:    c.pcWrite = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // Next-state and retirement decision.
  always_comb begin
    stateNext = stateQ;
    opNext    = opQ;
    retire    = 1'b0;
    case (stateQ)
      IDLE:  stateNext = FETCH;
      FETCH: if (mem_ready_i) stateNext = DECODE;
      DECODE: begin
        // The IR was loaded at the end of FETCH, so the opcode is valid now.
        opNext = instr_op_i;
        if (!isKnownOp(instr_op_i)) stateNext = FETCH;
`ifdef MCC_JUMP_EN
        else if (instr_op_i == OpJ) stateNext = JUMP;
`endif
        else stateNext = EXEC;
      end
      EXEC: begin
        case (opQ)
          OpR, OpAddi, OpSlti: stateNext = WB;
          OpLw, OpSw:          stateNext = MEM;
          OpBeq, OpBne: begin
            stateNext = FETCH;
            retire    = 1'b1;
          end
          default:             stateNext = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ready_i) begin
          if (opQ == OpLw) begin
            stateNext = WB;
          end else begin
            stateNext = FETCH;
            retire    = 1'b1;
          end
        end
      end
      WB: begin
        stateNext = FETCH;
        retire    = 1'b1;
      end
      JUMP: begin
        stateNext = FETCH;
        retire    = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Controls are registered from the next state, so they line up with stateQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stateQ <= IDLE;
      opQ    <= '0;
      cntQ   <= '0;
      ctrlQ  <= '0;
    end else begin
      stateQ <= stateNext;
      opQ    <= opNext;
      ctrlQ  <= decodeCtrl(stateNext, opNext);
      if (retire) cntQ <= cntQ + CNT_W'(1);
    end
  end

  // The IR load and PC increment must land on the same cycle the fetch
  // completes, so they follow mem_ready_i directly. Gating with rst_i keeps
  // a reset cycle free of strobes.
  assign fetchDone = (stateQ == FETCH) && mem_ready_i && !rst_i;

  assign PCWrite_o   = ctrlQ.pcWrite | fetchDone;
  assign IRWrite_o   = fetchDone;
  assign RegWrite_o  = ctrlQ.regWrite;
  assign ALUSrc_o    = ctrlQ.aluSrc;
  assign RegDst_o    = ctrlQ.regDst;
  assign Branch_o    = ctrlQ.branch;
  assign MemWrite_o  = ctrlQ.memWrite;
  assign MemRead_o   = ctrlQ.memRead;
  assign MemtoReg_o  = ctrlQ.memtoReg;
  assign ALU_op_o    = ALU_OP_W'(ctrlQ.aluOp);
  assign state_o     = stateQ;
  assign instr_cnt_o = cntQ;

  // The opcode is only in opQ after DECODE, so the flag has to look at the
  // IR field directly during DECODE.
  assign illegal_o = (stateQ == DECODE) && !isKnownOp(instr_op_i) && !rst_i;

endmodule

// File: tb/tb_multi_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control
//   Directed bench. An instruction-level model expands each instruction into
//   its per-cycle stimulus and expected outputs. One loop drives the inputs
//   and compares every cycle. Two DUTs share the stimulus. The default one has
//   CNT_W=16. The second has CNT_W=4 and ALU_OP_W=4, which exercises counter
//   wrap and ALU_op zero-extension.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control;

  localparam logic [5:0] opR    = 6'b000000;
  localparam logic [5:0] opAddi = 6'b001000;
  localparam logic [5:0] opSlti = 6'b001010;
  localparam logic [5:0] opLw   = 6'b100011;
  localparam logic [5:0] opSw   = 6'b101011;
  localparam logic [5:0] opBeq  = 6'b000100;
  localparam logic [5:0] opBne  = 6'b000101;
  localparam logic [5:0] opJ    = 6'b000010;
`ifdef MCC_JUMP_EN
  localparam bit jumpEn = 1'b1;
`else
  localparam bit jumpEn = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       pc, ir, rw, as, rd, br, mw, mr, m2r, ill;
    logic [2:0] alu;
  } obsT;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [5:0] op;
    obsT        exp;
    int         cnt;
    int         tag;
    bit         last;
    int         pin16;
    int         pin4;
  } recT;

  logic       clk_i;
  logic       rst_i;
  logic [5:0] instr_op_i;
  logic       mem_ready_i;

  logic        PCWrite_o, IRWrite_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o;
  logic        MemWrite_o, MemRead_o, MemtoReg_o, illegal_o;
  logic [2:0]  ALU_op_o, state_o;
  logic [15:0] instr_cnt_o;

  logic        pcB, irB, rwB, asB, rdB, brB, mwB, mrB, m2rB, illB;
  logic [3:0]  aluB;
  logic [2:0]  stB;
  logic [3:0]  cntB;

  multi_cycle_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .RegWrite_o(RegWrite_o),
    .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .Branch_o(Branch_o),
    .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .MemtoReg_o(MemtoReg_o),
    .ALU_op_o(ALU_op_o), .state_o(state_o), .illegal_o(illegal_o),
    .instr_cnt_o(instr_cnt_o)
  );

  multi_cycle_control #(.ALU_OP_W(4), .CNT_W(4)) dutB (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(pcB), .IRWrite_o(irB), .RegWrite_o(rwB),
    .ALUSrc_o(asB), .RegDst_o(rdB), .Branch_o(brB),
    .MemWrite_o(mwB), .MemRead_o(mrB), .MemtoReg_o(m2rB),
    .ALU_op_o(aluB), .state_o(stB), .illegal_o(illB),
    .instr_cnt_o(cntB)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  recT q[$];
  int  mcnt, curTag, pend16, pend4;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;

  function automatic obsT blank(input logic [2:0] st);
    obsT e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input logic rst, input logic rdy, input logic [5:0] op,
                      input obsT e, input bit last);
    recT r;
    r.rst   = rst;
    r.rdy   = rdy;
    r.op    = op;
    r.exp   = e;
    r.cnt   = mcnt;
    r.tag   = curTag;
    r.last  = last;
    r.pin16 = pend16;
    r.pin4  = pend4;
    pend16  = -1;
    pend4   = -1;
    q.push_back(r);
  endtask

  // Expand one instruction into cycles. fw = fetch wait cycles, mw = MEM wait
  // cycles, rstInMem = pulse reset on the first MEM cycle (with ready high).
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw, input bit rstInMem);
    obsT e;
    bit  isR, isI, isLw, isSw, isBr, isJ, known;
    isR   = (op == opR);
    isI   = (op == opAddi) || (op == opSlti);
    isLw  = (op == opLw);
    isSw  = (op == opSw);
    isBr  = (op == opBeq) || (op == opBne);
    isJ   = (op == opJ) && jumpEn;
    known = isR || isI || isLw || isSw || isBr || isJ;

    for (int k = 0; k < fw; k++) begin
      e = blank(3'd1); e.mr = 1'b1;
      push(1'b0, 1'b0, op, e, 1'b0);
    end
    e = blank(3'd1); e.mr = 1'b1; e.ir = 1'b1; e.pc = 1'b1;
    push(1'b0, 1'b1, op, e, 1'b0);

    e = blank(3'd2); e.ill = !known;
    push(1'b0, 1'b1, op, e, !known);
    if (!known) return;

    if (isJ) begin
      e = blank(3'd6); e.pc = 1'b1;
      push(1'b0, 1'b1, op, e, 1'b1);
      mcnt++;
      return;
    end

    e = blank(3'd3);
    if (isR)              e.alu = 3'b010;
    else if (isBr)        e.alu = 3'b001;
    else if (op == opSlti) e.alu = 3'b011;
    else                  e.alu = 3'b000;
    e.as = isI || isLw || isSw;
    e.br = isBr;
    push(1'b0, 1'b1, op, e, isBr);
    if (isBr) begin
      mcnt++;
      return;
    end

    if (isLw || isSw) begin
      e = blank(3'd4); e.mr = isLw; e.mw = isSw;
      if (rstInMem) begin
        push(1'b1, 1'b1, op, e, 1'b0);
        mcnt   = 0;
        pend16 = 0;
        push(1'b0, 1'b1, op, blank(3'd0), 1'b1);
        return;
      end
      for (int k = 0; k < mw; k++) push(1'b0, 1'b0, op, e, 1'b0);
      push(1'b0, 1'b1, op, e, isSw);
      if (isSw) begin
        mcnt++;
        return;
      end
    end

    e = blank(3'd5); e.rw = 1'b1; e.rd = isR; e.m2r = isLw;
    push(1'b0, 1'b1, op, e, 1'b1);
    mcnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    recT r;
    obsT obs, obsBv;
    int  tag2Cycles, tag2Mr, illCnt;
    tag2Cycles = 0; tag2Mr = 0; illCnt = 0;
    rst_i = 1'b1; mem_ready_i = 1'b1; instr_op_i = 6'd0;
    mcnt = 0; curTag = 0; pend16 = -1; pend4 = -1;

    // Two reset edges with ready high, then one IDLE cycle.
    push(1'b1, 1'b1, 6'd0, blank(3'd0), 1'b0);
    push(1'b0, 1'b1, 6'd0, blank(3'd0), 1'b0);

    runInstr(opR, 0, 0, 1'b0);
    pend16 = 1;
    runInstr(opAddi, 0, 0, 1'b0);
    runInstr(opSlti, 0, 0, 1'b0);
    runInstr(opBeq, 0, 0, 1'b0);
    runInstr(opBne, 0, 0, 1'b0);
    runInstr(opSw, 0, 0, 1'b0);
    runInstr(opLw, 0, 0, 1'b0);
    curTag = 2;
    runInstr(opLw, 0, 3, 1'b0);
    curTag = 0;
    runInstr(opAddi, 2, 0, 1'b0);
    runInstr(6'b111111, 0, 0, 1'b0);
    runInstr(opJ, 0, 0, 1'b0);
    runInstr(opR, 0, 0, 1'b0);
    runInstr(opSw, 0, 0, 1'b1);
    for (int k = 0; k < 17; k++) runInstr(opBeq, 0, 0, 1'b0);
    pend16 = 17;
    pend4  = 1;
    runInstr(opR, 0, 0, 1'b0);

    @(posedge clk_i);
    while (q.size() > 0) begin
      r = q.pop_front();
      #1;
      rst_i       = r.rst;
      mem_ready_i = r.rdy;
      instr_op_i  = r.op;
      @(negedge clk_i);
      obs   = {state_o, PCWrite_o, IRWrite_o, RegWrite_o, ALUSrc_o, RegDst_o, Branch_o,
               MemWrite_o, MemRead_o, MemtoReg_o, illegal_o, ALU_op_o};
      obsBv = {stB, pcB, irB, rwB, asB, rdB, brB, mwB, mrB, m2rB, illB, aluB[2:0]};
      checkVal("ctrl", 32'(obs), 32'(r.exp));
      checkVal("cnt16", 32'(instr_cnt_o), 32'(r.cnt % 65536));
      checkVal("ctrlB", 32'(obsBv), 32'(r.exp));
      checkVal("aluB_msb", 32'(aluB[3]), 32'(0));
      checkVal("cnt4", 32'(cntB), 32'(r.cnt % 16));
      if (r.pin16 >= 0) checkVal("pin_cnt16", 32'(instr_cnt_o), 32'(r.pin16));
      if (r.pin4 >= 0)  checkVal("pin_cnt4", 32'(cntB), 32'(r.pin4));
      if (r.tag == 2 && state_o != 3'd0) tag2Cycles++;
      if (r.tag == 2 && state_o == 3'd4 && MemRead_o) tag2Mr++;
      if (illegal_o) illCnt++;
      if (r.last)
        $display("txn op=%b rst=%0b done_cycle=%0d state=%0d cnt=%0d",
                 r.op, r.rst, cyc, state_o, instr_cnt_o);
      cyc++;
      @(posedge clk_i);
    end

    checkVal("lw_wait_cycles", 32'(tag2Cycles), 32'(8));
    checkVal("lw_memread_cycles", 32'(tag2Mr), 32'(4));
    checkVal("illegal_pulses", 32'(illCnt), jumpEn ? 32'(1) : 32'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
